id_hazard_ctrl: RTL

- Parametrised operand-resolution and hazard controller for the decode stage; successor to the fixed two-source EX/MEM forwarding and load-use stall logic.
- Resolves NUM_RD_PORTS source operands from NUM_FWD in-flight pipeline stages, a long-latency writeback bypass and the regfile.
- Keeps a registered scoreboard of destinations owned by outstanding long-latency ops (mul/div), and raises stall to pipeline_ctrl for RAW, WAW and capacity hazards.

---
 rtl/id_hazard_ctrl_pkg.sv | 23 ++
 rtl/id_operand_mux.sv | 63 ++++++
 rtl/id_hazard_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// id_hazard_ctrl_pkg
// Shared constants and types for the decode-stage operand and hazard logic.
//   XLEN_DEFAULT : default operand width
//   REG_AW       : architectural register address width
//   NUM_REGS     : number of architectural registers (x0..x31)
//   hz_cause_e   : why decode is being held; HZ_NONE means free to issue
// ----------------------------------------------------------------------------
package id_hazard_ctrl_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int REG_AW       = 5;
    localparam int NUM_REGS     = 32;

    typedef enum logic [2:0] {
        HZ_NONE,      // no hazard
        HZ_RAW_FWD,   // source produced by an in-flight stage whose data is not ready yet
        HZ_RAW_LONG,  // source owned by an outstanding long-latency op
        HZ_WAW,       // destination still owned by an outstanding long-latency op
        HZ_CAP        // long-latency unit has no free slot
    } hz_cause_e;

endpackage

// File: rtl/id_operand_mux.sv
// ----------------------------------------------------------------------------
// id_operand_mux
// Resolves one source operand for the decode stage and flags a RAW hazard.
// Priority: unread/x0 -> 0, youngest matching forwarding stage,
// long-latency writeback bypass, then regfile data.
// Ports:
//   rs_read_i / rs_addr_i / rf_data_i : operand request and regfile data
//   pending_i                         : scoreboard bit for rs_addr_i
//   fwd_*_i                           : NUM_FWD forwarding stages, index 0 youngest
//   long_wb_*_i                       : long-latency writeback bypass
//   op_data_o                         : resolved operand
//   cause_o                           : HZ_NONE, HZ_RAW_FWD or HZ_RAW_LONG
// ----------------------------------------------------------------------------
module id_operand_mux
    import id_hazard_ctrl_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int NUM_FWD = 2
) (
    input  logic                      rs_read_i,
    input  logic [REG_AW-1:0]         rs_addr_i,
    input  logic [XLEN-1:0]           rf_data_i,
    input  logic                      pending_i,
    input  logic [NUM_FWD-1:0]        fwd_ena_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i,
    input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
    input  logic [NUM_FWD-1:0]        fwd_dvld_i,
    input  logic                      long_wb_ena_i,
    input  logic [REG_AW-1:0]         long_wb_addr_i,
    input  logic [XLEN-1:0]           long_wb_data_i,
    output logic [XLEN-1:0]           op_data_o,
    output hz_cause_e                 cause_o
);

    logic wb_hit;
    logic sel_dvld;

    // NOTE: every output of this combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        op_data_o = '0;
        cause_o   = HZ_NONE;
        sel_dvld  = 1'b1;
        wb_hit    = long_wb_ena_i && (long_wb_addr_i == rs_addr_i);

        if (rs_read_i && (rs_addr_i != '0)) begin
            op_data_o = wb_hit ? long_wb_data_i : rf_data_i;
            // Walk oldest to youngest so the lowest-index match is written last and wins.
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (fwd_ena_i[k] && (fwd_addr_i[k*REG_AW +: REG_AW] == rs_addr_i)) begin
                    op_data_o = fwd_data_i[k*XLEN +: XLEN];
                    sel_dvld  = fwd_dvld_i[k];
                end
            end
            if (!sel_dvld) begin
                cause_o = HZ_RAW_FWD;
            end else if (pending_i && !wb_hit) begin
                cause_o = HZ_RAW_LONG;
            end
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// id_hazard_ctrl
// Decode-stage operand resolution and hazard control. Operands are resolved
// combinationally from forwarding stages, the long-latency writeback bypass
// and the regfile. A scoreboard tracks destinations of outstanding long ops
// and raises stall for RAW, WAW and long-unit capacity hazards.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   id_valid_i, flush_i : decode instruction valid / killed this cycle
//   rs_*_i, rf_data_i   : per-port source requests and regfile data
//   rd_w_ena_i, rd_addr_i, is_long_i : destination and op class
//   fwd_*_i             : forwarding stages, index 0 youngest (EX)
//   long_wb_*_i         : long-unit writeback
//   op_data_o           : resolved operands
//   stall_o, issue_o    : hold decode / instruction leaves decode
//   long_cnt_o          : outstanding long-op count
//   stall_cycles_o      : wrapping count of stalled cycles
// ----------------------------------------------------------------------------
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int NUM_RD_PORTS = 2,
    parameter int NUM_FWD      = 2,
    parameter int MAX_LONG     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid_i,
    input  logic                           flush_i,
    input  logic [NUM_RD_PORTS-1:0]        rs_read_i,
    input  logic [NUM_RD_PORTS*REG_AW-1:0] rs_addr_i,
    input  logic [NUM_RD_PORTS*XLEN-1:0]   rf_data_i,
    input  logic                           rd_w_ena_i,
    input  logic [REG_AW-1:0]              rd_addr_i,
    input  logic                           is_long_i,
    input  logic [NUM_FWD-1:0]             fwd_ena_i,
    input  logic [NUM_FWD*REG_AW-1:0]      fwd_addr_i,
    input  logic [NUM_FWD*XLEN-1:0]        fwd_data_i,
    input  logic [NUM_FWD-1:0]             fwd_dvld_i,
    input  logic                           long_wb_ena_i,
    input  logic [REG_AW-1:0]              long_wb_addr_i,
    input  logic [XLEN-1:0]                long_wb_data_i,
    output logic [NUM_RD_PORTS*XLEN-1:0]   op_data_o,
    output logic                           stall_o,
    output logic                           issue_o,
    output logic [$clog2(MAX_LONG):0]      long_cnt_o,
    output logic [31:0]                    stall_cycles_o
);

    localparam int              CW      = $clog2(MAX_LONG) + 1;
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_LONG);

    logic [NUM_REGS-1:0]         pending_q, pending_d;
    logic [CW-1:0]               long_cnt_q, long_cnt_d;
    logic [31:0]                 stall_cycles_q, stall_cycles_d;
    logic [NUM_RD_PORTS*XLEN-1:0] op_data;
    hz_cause_e                   port_cause [NUM_RD_PORTS];
    hz_cause_e                   hz_cause;
    logic                        active;
    logic                        long_issue;

    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_port
        id_operand_mux #(
            .XLEN    (XLEN),
            .NUM_FWD (NUM_FWD)
        ) u_mux (
            .rs_read_i      (rs_read_i[g]),
            .rs_addr_i      (rs_addr_i[g*REG_AW +: REG_AW]),
            .rf_data_i      (rf_data_i[g*XLEN +: XLEN]),
            .pending_i      (pending_q[rs_addr_i[g*REG_AW +: REG_AW]]),
            .fwd_ena_i      (fwd_ena_i),
            .fwd_addr_i     (fwd_addr_i),
            .fwd_data_i     (fwd_data_i),
            .fwd_dvld_i     (fwd_dvld_i),
            .long_wb_ena_i  (long_wb_ena_i),
            .long_wb_addr_i (long_wb_addr_i),
            .long_wb_data_i (long_wb_data_i),
            .op_data_o      (op_data[g*XLEN +: XLEN]),
            .cause_o        (port_cause[g])
        );
    end

    // First hazard found wins; the cause only matters for debug, any non-NONE stalls.
    always_comb begin
        hz_cause = HZ_NONE;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (hz_cause == HZ_NONE) hz_cause = port_cause[p];
        end
        if ((hz_cause == HZ_NONE) && rd_w_ena_i && (rd_addr_i != '0) && pending_q[rd_addr_i]
            && !(long_wb_ena_i && (long_wb_addr_i == rd_addr_i))) begin
            hz_cause = HZ_WAW;
        end
        if ((hz_cause == HZ_NONE) && is_long_i && (long_cnt_q == MAX_CNT) && !long_wb_ena_i) begin
            hz_cause = HZ_CAP;
        end
    end

    // Outputs are forced quiet while reset is held, without waiting for a clock.
    assign active     = rst && id_valid_i && !flush_i;
    assign stall_o    = active && (hz_cause != HZ_NONE);
    assign issue_o    = active && (hz_cause == HZ_NONE);
    assign op_data_o  = rst ? op_data : '0;
    assign long_issue = issue_o && is_long_i;

    // NOTE: next-state logic uses blocking assignments in always_comb so later
    // statements see earlier ones; the registers below use non-blocking only.
    always_comb begin
        pending_d = pending_q;
        if (long_wb_ena_i) pending_d[long_wb_addr_i] = 1'b0;
        // A same-cycle set of the same register is applied last so it wins.
        if (long_issue && rd_w_ena_i) pending_d[rd_addr_i] = 1'b1;
        pending_d[0] = 1'b0;

        long_cnt_d = long_cnt_q;
        case ({long_issue, long_wb_ena_i})
            2'b10:   long_cnt_d = long_cnt_q + 1'b1;
            2'b01:   if (long_cnt_q != '0) long_cnt_d = long_cnt_q - 1'b1;
            default: long_cnt_d = long_cnt_q;
        endcase

        stall_cycles_d = stall_cycles_q + {31'b0, stall_o};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q      <= '0;
            long_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            pending_q      <= pending_d;
            long_cnt_q     <= long_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign long_cnt_o     = long_cnt_q;
    assign stall_cycles_o = stall_cycles_q;

    // A writeback with nothing outstanding means the long unit and decode disagree.
    a_no_dec_at_zero: assert property (@(posedge clk) disable iff (!rst)
        (long_wb_ena_i && !long_issue) |-> (long_cnt_q != '0));
    a_no_inc_at_max: assert property (@(posedge clk) disable iff (!rst)
        (long_issue && !long_wb_ena_i) |-> (long_cnt_q != MAX_CNT));

endmodule
